// File: rtl/button_led_pkg.sv
// Shared mode encoding and small bit-vector helpers for the front-panel controller.
// Helpers take 32-bit vectors; callers zero-extend narrower inputs and slice the result.
package button_led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DIRECT = 2'b00;
  localparam mode_t MODE_LATCH  = 2'b01;
  localparam mode_t MODE_COUNT  = 2'b10;
  localparam mode_t MODE_OFF    = 2'b11;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [31:0] onehot_lowest(input logic [31:0] vec);
    return vec & (~vec + 32'd1);
  endfunction

  function automatic logic popcount_gt1(input logic [31:0] vec);
    return (vec & (vec - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, debounce counter, accepted level and
// a registered one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 24000
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_m;
  logic          sync_s;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_m   <= 1'b0;
      sync_s   <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      pulse    <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_m   <= pin;
      sync_s   <= sync_m;
      stable_q <= stable;
      pulse    <= stable & ~stable_q;
      // Any return to the accepted level restarts the qualification window.
      if (sync_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_led_ctrl.sv
// Front-panel controller: debounced buttons and synchronised switches drive
// the green (mode pattern) and red (saturating press count) LEDs.
// Optional multi-press blink in DIRECT mode: define BUTTON_LED_BLINK_EN.
module button_led_ctrl
  import button_led_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 8,
  parameter int N_RED           = 7,
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int BLINK_DIV       = 12000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SW-1:0]  toggle_switch,
  input  logic [N_BTN-1:0] push_button,
  output logic [N_RED-1:0] red_led,
  output logic [N_BTN-1:0] green_led,
  output logic [N_BTN-1:0] press_pulse
);

  logic [N_SW-1:0]  sw_m;
  logic [N_SW-1:0]  sw_s;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] pulse;
  logic [N_BTN-1:0] latch_q;
  logic [N_BTN-1:0] latch_next;
  logic [N_BTN-1:0] direct_pat;
  logic [N_BTN-1:0] green_next;
  logic [N_RED-1:0] press_cnt;
  logic [N_RED-1:0] cnt_next;
  logic [31:0]      lowest_w;
  mode_t            mode;
  logic             clr;
  logic             any_pulse;
  logic             multi;
  logic             unused_bits;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .pin   (push_button[i]),
      .stable(stable[i]),
      .pulse (pulse[i])
    );
  end

  assign mode        = sw_s[1:0];
  assign clr         = sw_s[N_SW-1];
  assign any_pulse   = |pulse;
  assign lowest_w    = onehot_lowest(32'(pulse));
  assign multi       = popcount_gt1(32'(stable));
  assign unused_bits = ^{sw_s, lowest_w};

`ifdef BUTTON_LED_BLINK_EN
  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [PW-1:0] presc;
  logic          blink_off;
  logic          blink_cond;

  assign blink_cond = (mode == MODE_DIRECT) && multi;

  // Held at 0 / phase on whenever the blink condition is absent, so each
  // new multi-press starts with a full on half-period.
  always_ff @(posedge clock) begin
    if (reset || !blink_cond) begin
      presc     <= '0;
      blink_off <= 1'b0;
    end else if (presc == PW'(BLINK_DIV - 1)) begin
      presc     <= '0;
      blink_off <= ~blink_off;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign direct_pat = multi ? {N_BTN{~blink_off}} : stable;
`else
  assign direct_pat = multi ? {N_BTN{1'b1}} : stable;
`endif

  always_comb begin
    cnt_next = press_cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (any_pulse && (press_cnt != {N_RED{1'b1}})) begin
      cnt_next = press_cnt + N_RED'(1);
    end
    latch_next = any_pulse ? lowest_w[N_BTN-1:0] : latch_q;
    green_next = '0;
    case (mode)
      MODE_DIRECT: green_next = direct_pat;
      MODE_LATCH:  green_next = latch_next;
      MODE_COUNT:  green_next = cnt_next[N_BTN-1:0];
      MODE_OFF:    green_next = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_m      <= '0;
      sw_s      <= '0;
      press_cnt <= '0;
      latch_q   <= '0;
      green_led <= '0;
    end else begin
      sw_m      <= toggle_switch;
      sw_s      <= sw_m;
      press_cnt <= cnt_next;
      latch_q   <= latch_next;
      green_led <= green_next;
    end
  end

  assign red_led     = press_cnt;
  assign press_pulse = pulse;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Self-checking bench for button_led_ctrl: directed scenarios plus random
// button/switch activity compared every cycle against a behavioural model.
module tb_button_led_ctrl;

  localparam int N_BTN = 4;
  localparam int N_SW  = 8;
  localparam int N_RED = 7;
  localparam int DC    = 4;
  localparam int BD    = 8;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N_SW-1:0]  toggle_switch = '0;
  logic [N_BTN-1:0] push_button = '0;
  logic [N_RED-1:0] red_led;
  logic [N_BTN-1:0] green_led;
  logic [N_BTN-1:0] press_pulse;

  always #5 clock = ~clock;

  button_led_ctrl #(
    .N_BTN(N_BTN), .N_SW(N_SW), .N_RED(N_RED),
    .DEBOUNCE_CYCLES(DC), .BLINK_DIV(BD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .toggle_switch(toggle_switch),
    .push_button  (push_button),
    .red_led      (red_led),
    .green_led    (green_led),
    .press_pulse  (press_pulse)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_bad    = 0;
  int pulse_seen[N_BTN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Pins reach the logic two samples late; a button's accepted level flips
  // once the last DC observed samples all disagree with it.
  logic [N_BTN-1:0] m_btn_d1 = '0, m_btn_d2 = '0;
  logic [N_SW-1:0]  m_sw_d1 = '0, m_sw_d2 = '0;
  logic [N_BTN-1:0] m_win[$];
  logic [N_BTN-1:0] m_stable = '0, m_stable_old = '0, m_pulse = '0;
  logic [N_BTN-1:0] m_latch = '0, m_green = '0;
  logic [N_RED-1:0] m_cnt = '0;
  int               m_run = 0;

  function automatic logic [N_BTN-1:0] lowest_bit(input logic [N_BTN-1:0] v);
    for (int i = 0; i < N_BTN; i++) if (v[i]) return N_BTN'(1) << i;
    return '0;
  endfunction

  task automatic model_step();
    logic [N_BTN-1:0] seen_btn, n_stable, n_latch, n_green;
    logic [N_SW-1:0]  seen_sw;
    logic [N_RED-1:0] n_cnt;
    logic [1:0]       mode;
    int               ones;
    bit               all_diff;
    if (reset) begin
      m_btn_d1 = '0; m_btn_d2 = '0; m_sw_d1 = '0; m_sw_d2 = '0;
      m_win.delete();
      m_stable = '0; m_stable_old = '0; m_pulse = '0;
      m_latch = '0; m_green = '0; m_cnt = '0; m_run = 0;
      return;
    end
    seen_btn = m_btn_d2;
    seen_sw  = m_sw_d2;
    mode     = seen_sw[1:0];
    ones     = $countones(m_stable);

    if (seen_sw[N_SW-1]) n_cnt = '0;
    else if (m_pulse != 0 && int'(m_cnt) < (1 << N_RED) - 1) n_cnt = m_cnt + N_RED'(1);
    else n_cnt = m_cnt;

    n_latch = (m_pulse != 0) ? lowest_bit(m_pulse) : m_latch;

    case (mode)
      2'd0: n_green = (ones > 1) ? '1 : m_stable;
      2'd1: n_green = n_latch;
      2'd2: n_green = n_cnt[N_BTN-1:0];
      default: n_green = '0;
    endcase
`ifdef BUTTON_LED_BLINK_EN
    if (mode == 2'd0 && ones > 1) begin
      n_green = ((m_run / BD) % 2 == 0) ? '1 : '0;
      m_run++;
    end else begin
      m_run = 0;
    end
`endif

    m_win.push_back(seen_btn);
    if (m_win.size() > DC) void'(m_win.pop_front());
    n_stable = m_stable;
    if (m_win.size() == DC) begin
      for (int i = 0; i < N_BTN; i++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) n_stable[i] = ~m_stable[i];
      end
    end

    m_pulse      = m_stable & ~m_stable_old;
    m_stable_old = m_stable;
    m_stable     = n_stable;
    m_cnt        = n_cnt;
    m_latch      = n_latch;
    m_green      = n_green;
    m_btn_d2     = m_btn_d1;
    m_btn_d1     = push_button;
    m_sw_d2      = m_sw_d1;
    m_sw_d1      = toggle_switch;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
    check("green", 32'(green_led), 32'(m_green));
    check("red", 32'(red_led), 32'(m_cnt));
    check("pulse", 32'(press_pulse), 32'(m_pulse));
    for (int i = 0; i < N_BTN; i++) pulse_seen[i] += int'(press_pulse[i]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_green", 32'(green_led), 32'h0);
    check("rst_red", 32'(red_led), 32'h0);
    check("rst_pulse", 32'(press_pulse), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < N_BTN; i++) pulse_seen[i] = 0;
  endtask

  task automatic press(input logic [N_BTN-1:0] mask, input int hold, input int gap);
    push_button = mask;
    ticks(hold);
    push_button = '0;
    ticks(gap);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: DIRECT, single button, latency and one pulse
    do_reset();
    toggle_switch = 8'h00;
    push_button = 4'b0100;
    ticks(6);
    check("t1_green_early", 32'(green_led), 32'h0);
    tick();
    check("t1_green", 32'(green_led), 32'h4);
    check("t1_pulse", 32'(press_pulse), 32'h4);
    ticks(5);
    check("t1_pulse_count", 32'(pulse_seen[2]), 32'd1);
    push_button = '0;
    ticks(8);
    check("t1_release", 32'(green_led), 32'h0);

    // 2: bounce shorter than the debounce window is rejected
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_button[0] = ~push_button[0];
      ticks(2);
    end
    push_button = '0;
    ticks(8);
    check("t2_green", 32'(green_led), 32'h0);
    check("t2_pulses", 32'(pulse_seen[0]), 32'd0);
    check("t2_red", 32'(red_led), 32'h0);

    // 3: two buttons in DIRECT
    push_button = 4'b1001;
    ticks(8);
    check("t3_multi", 32'(green_led), 32'hF);
`ifdef BUTTON_LED_BLINK_EN
    ticks(8);
    check("t3_blink_off", 32'(green_led), 32'h0);
    ticks(8);
    check("t3_blink_on", 32'(green_led), 32'hF);
`endif
    push_button = '0;
    ticks(8);

    // 4: LATCH mode
    toggle_switch = 8'h01;
    ticks(3);
    press(4'b0010, 8, 8);
    check("t4_latch_b1", 32'(green_led), 32'h2);
    push_button = 4'b1000;
    ticks(8);
    check("t4_latch_b3", 32'(green_led), 32'h8);
    push_button = '0;
    ticks(8);
    check("t4_latch_hold", 32'(green_led), 32'h8);
    press(4'b0101, 8, 8);
    check("t4_latch_lowest", 32'(green_led), 32'h1);

    // 5: COUNT mode, saturation and clear
    do_reset();
    toggle_switch = 8'h02;
    for (int i = 0; i < 130; i++) press(4'b0001, 6, 6);
    check("t5_red_sat", 32'(red_led), 32'h7F);
    check("t5_green_cnt", 32'(green_led), 32'hF);
    toggle_switch = 8'h82;
    ticks(3);
    check("t5_clr_red", 32'(red_led), 32'h0);
    check("t5_clr_green", 32'(green_led), 32'h0);
    press(4'b0001, 8, 8);
    check("t5_clr_hold", 32'(red_led), 32'h0);

    // 6: reset while a button is held
    do_reset();
    toggle_switch = 8'h02;
    ticks(3);
    for (int i = 0; i < 4; i++) press(4'b0010, 6, 6);
    push_button = 4'b0010;
    ticks(10);
    check("t6_red5", 32'(red_led), 32'h5);
    do_reset();
    ticks(10);
    check("t6_red1", 32'(red_led), 32'h1);
    push_button = '0;
    ticks(8);

    // random activity against the model
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      push_button = N_BTN'($urandom_range(0, 15));
      toggle_switch = {($urandom_range(0, 7) == 0), 5'b0, 2'($urandom_range(0, 3))};
      ticks($urandom_range(1, 8));
    end
    push_button = '0;
    toggle_switch = '0;
    ticks(10);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
